fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
- Read-side consumer of the 8-bit async FIFO, in the rclk domain; drains the FIFO through rinc/rempty/rdata.
- Packs PACK consecutive bytes into one wide word, first byte popped in the least-significant lane, and presents the word on a valid/ready output port.
- Accepts a flush request that emits a partially filled word, so the bench scoreboard and downstream logic can close out traffic.

Parameters:
- DSIZE, 8, FIFO data width in bits; must match the FIFO instance.
- PACK, 4, number of FIFO entries per output word; legal range 2..16.
- CW, 16, width of the output word counter.

Ports:
- rclk  in  1  read-domain clock; the FIFO read clock.
- rrst_n  in  1  asynchronous active-low reset, rclk domain.
- rempty  in  1  FIFO empty flag; when low, rdata holds valid data (first-word fall-through).
- rdata  in  DSIZE  FIFO read data.
- rinc  out  1  FIFO pop; combinational; a byte is consumed on each rclk edge where rinc=1.
- flush  in  1  single-cycle request to emit the partial word.
- out_valid  out  1  output word valid, registered.
- out_ready  in  1  downstream accept.
- out_data  out  DSIZE*PACK  packed word; byte k in bits [k*DSIZE +: DSIZE].
- out_bytes  out  $clog2(PACK+1)  number of valid byte lanes in out_data (1..PACK).
- busy  out  1  high when idx!=0 or flush_pend=1.
- words_out  out  CW  count of completed output handshakes; wraps modulo 2^CW.

Behaviour:
- Asynchronous reset, active low. Clears idx, acc, flush_pend, out_valid, out_data, out_bytes and words_out to 0. rinc is forced to 0 while rrst_n is low.
- Internal state:
  - idx: fill index, 0..PACK-1.
  - acc: accumulator, DSIZE*PACK bits.
  - flush_pend: registered flag.
  - Two-state FSM: FILL (flush_pend=0) and FLUSH (flush_pend=1).
- can_out = !out_valid || out_ready. The output register is free, or is being emptied this edge.
- rinc (FILL state only) = !rempty && (idx!=PACK-1 || can_out). In FLUSH state rinc=0.
- Pop edge with idx<PACK-1: acc[idx lane] <= rdata; idx++.
- Pop edge with idx==PACK-1: out_data <= {rdata, acc lanes 0..PACK-2}; out_bytes <= PACK; out_valid <= 1; idx <= 0; acc <= 0.
  - Zero-bubble: a full word can complete on the same edge the previous word handshakes.
- Output handshake: an edge with out_valid && out_ready increments words_out. out_valid drops unless a new word loads on the same edge. out_data and out_bytes hold stable while out_valid && !out_ready.
- Flush:
  - flush=1 sampled in FILL sets flush_pend. A pop on that same edge is still performed, and its byte belongs to the flushed word.
  - Exception: if that pop completes a full word, the full word is emitted and the flush finds idx=0.
- In FLUSH, on the first edge with can_out:
  - If idx>0: out_data <= acc (unused lanes zero); out_bytes <= idx; out_valid <= 1; idx <= 0; acc <= 0.
  - If idx==0: no word is emitted.
  - In both cases flush_pend clears and the FSM returns to FILL.
- flush asserted while in FLUSH is ignored (no queuing).
- rempty rising mid-word: popping stops and idx/acc hold indefinitely. No timeout; only flush closes a partial word.
- rrst_n deasserting mid-word: the partial word is discarded, with no emission.
- Latency: the last byte's pop edge to out_valid high is 1 rclk.
- Sustained throughput: 1 byte/cycle while !rempty and out_ready=1.

Test Plan:
- Reset, then write 0x11,0x22,0x33,0x44 via the write side; out_ready=1 -> exactly 4 rinc pulses; out_data=0x44332211, out_bytes=4; out_valid high for 1 cycle; words_out=1.
- Stream 12 bytes 0x00..0x0B with out_ready=1 -> words 0x03020100, 0x07060504, 0x0B0A0908 on consecutive completions; words_out=3; no rinc while rempty=1.
- out_ready=0 with 8 bytes queued -> first word held stable; 3 further pops (idx reaches 3), then rinc=0; raising out_ready gives the second word on the next edge with no byte loss.
- Write 0xA1,0xB2, then pulse flush -> out_data=0x0000B2A1, out_bytes=2, busy clears; flush again with idx=0 -> no output.
- Flush pulse on the same edge as the pop of 0xC3 (idx=2, acc holds 0xC1,0xC2) -> out_data=0x00C3C2C1, out_bytes=3.
- Assert rrst_n=0 mid-word (idx=2) -> out_valid=0, words_out=0, rinc=0; after release, next 4 bytes form a clean word.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer of the 8-bit async FIFO (rclk domain).
// It pops bytes from a first-word-fall-through FIFO and packs PACK of them into
// one wide word. The first byte popped goes into the least-significant lane.
// The word is presented on a valid/ready port. A flush pulse closes out a
// partially filled word.
//
// Ports:
//   rclk, rrst_n  read clock, asynchronous active-low reset
//   rempty, rdata FIFO empty flag and read data (valid while rempty=0)
//   rinc          FIFO pop, combinational; one byte per rclk edge with rinc=1
//   flush         single-cycle request to emit the partial word
//   out_valid     output word valid (registered)
//   out_ready     downstream accept
//   out_data      packed word; byte k in bits [k*DSIZE +: DSIZE]
//   out_bytes     number of valid byte lanes in out_data (1..PACK)
//   busy          a partial word is held or a flush is pending
//   words_out     count of completed output handshakes (wraps)
module fifo_rd_packer #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned PACK  = 4,
    parameter int unsigned CW    = 16,
    localparam int unsigned BW   = $clog2(PACK + 1)
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DSIZE*PACK-1:0] out_data,
    output logic [BW-1:0]         out_bytes,
    output logic                  busy,
    output logic [CW-1:0]         words_out
);

    localparam int unsigned IW = $clog2(PACK);

    // StFlush is the flush_pend=1 state.
    typedef enum logic {StFill, StFlush} state_e;

    state_e                  state;
    logic [IW-1:0]           idx;
    logic [DSIZE*PACK-1:0]   acc;
    logic                    can_out;
    logic                    last;

    // Output register is free, or is being emptied on this edge.
    assign can_out = !out_valid || out_ready;
    assign last    = (idx == IW'(PACK - 1));

    // The last byte of a word may only be popped when the output register can take it.
    assign rinc = rrst_n && (state == StFill) && !rempty && (!last || can_out);

    assign busy = (idx != '0) || (state == StFlush);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= StFill;
            idx       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            words_out <= '0;
        end else begin
            if (out_valid && out_ready) begin
                words_out <= words_out + CW'(1);
                out_valid <= 1'b0;
            end
            // Loads below override the out_valid clear, giving zero-bubble turnover.
            unique case (state)
                StFill: begin
                    if (rinc) begin
                        if (last) begin
                            out_data  <= {rdata, acc[DSIZE*(PACK-1)-1:0]};
                            out_bytes <= BW'(PACK);
                            out_valid <= 1'b1;
                            idx       <= '0;
                            acc       <= '0;
                        end else begin
                            acc[DSIZE*idx +: DSIZE] <= rdata;
                            idx                     <= idx + IW'(1);
                        end
                    end
                    // A pop on the flush edge still lands in the word being flushed.
                    if (flush) begin
                        state <= StFlush;
                    end
                end
                StFlush: begin
                    if (can_out) begin
                        if (idx != '0) begin
                            out_data  <= acc;
                            out_bytes <= BW'(idx);
                            out_valid <= 1'b1;
                            idx       <= '0;
                            acc       <= '0;
                        end
                        state <= StFill;
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

endmodule
